// File: rtl/hci_bank_qos_arbiter_pkg.sv
// Shared types for the HCI bank QoS arbiter: QoS control bundle and default counter width.
package hci_package;

  localparam int unsigned HCI_QOS_CNT_W = 8;

  typedef struct packed {
    logic [HCI_QOS_CNT_W-1:0] max_stall;
    logic                     invert_prio;
  } hci_qos_ctrl_t;

endpackage

// File: rtl/hci_bank_qos_arbiter_chan.sv
// One bank of the QoS arbiter: fixed-priority pick with starvation override,
// per-branch stall counters, and tracking of which branch owns the next-cycle response.
module hci_bank_qos_arbiter_chan
  import hci_package::*;
#(
  parameter int unsigned NB_BRANCH = 3,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned CNT_W     = HCI_QOS_CNT_W,
  parameter int unsigned BW        = DW / 8
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  hci_qos_ctrl_t                     ctrl_i,
  input  logic [NB_BRANCH-1:0]              req_i,
  input  logic [NB_BRANCH-1:0][AW-1:0]      add_i,
  input  logic [NB_BRANCH-1:0]              wen_i,
  input  logic [NB_BRANCH-1:0][DW-1:0]      data_i,
  input  logic [NB_BRANCH-1:0][BW-1:0]      be_i,
  output logic [NB_BRANCH-1:0]              gnt_o,
  output logic [NB_BRANCH-1:0]              r_valid_o,
  output logic                              mem_req_o,
  output logic [AW-1:0]                     mem_add_o,
  output logic                              mem_wen_o,
  output logic [DW-1:0]                     mem_data_o,
  output logic [BW-1:0]                     mem_be_o,
  input  logic                              mem_gnt_i
);

  localparam int unsigned IW = (NB_BRANCH > 1) ? $clog2(NB_BRANCH) : 1;

  logic [NB_BRANCH-1:0][CNT_W-1:0] cnt_q;
  logic [NB_BRANCH-1:0]            forced;
  logic [IW-1:0]                   winner;
  logic                            accept;
  logic                            resp_vld_p1;
  logic [IW-1:0]                   resp_idx_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NB_BRANCH; i++) begin
      forced[i] = req_i[i] && (ctrl_i.max_stall != '0) &&
                  (32'(cnt_q[i]) >= 32'(ctrl_i.max_stall));
    end
  end

  // Starving branches pre-empt plain priority; both scans follow the same order.
  always_comb begin
    logic          found_f, found_r;
    logic [IW-1:0] win_f, win_r;
    int            idx;
    found_f = 1'b0;
    found_r = 1'b0;
    win_f   = '0;
    win_r   = '0;
    for (int i = 0; i < NB_BRANCH; i++) begin
      idx = ctrl_i.invert_prio ? (NB_BRANCH - 1 - i) : i;
      if (!found_f && forced[idx]) begin
        found_f = 1'b1;
        win_f   = IW'(idx);
      end
      if (!found_r && req_i[idx]) begin
        found_r = 1'b1;
        win_r   = IW'(idx);
      end
    end
    winner = found_f ? win_f : win_r;
  end

  assign mem_req_o = |req_i;
  assign accept    = mem_req_o && mem_gnt_i;

  always_comb begin
    mem_add_o  = '0;
    mem_wen_o  = 1'b0;
    mem_data_o = '0;
    mem_be_o   = '0;
    gnt_o      = '0;
    r_valid_o  = '0;
    for (int i = 0; i < NB_BRANCH; i++) begin
      if (IW'(i) == winner) begin
        mem_add_o  = add_i[i];
        mem_wen_o  = wen_i[i];
        mem_data_o = data_i[i];
        mem_be_o   = be_i[i];
        gnt_o[i]   = accept;
      end
      r_valid_o[i] = resp_vld_p1 && (resp_idx_p1 == IW'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NB_BRANCH; i++) begin
        cnt_q[i] <= (req_i[i] && !gnt_o[i]) ? sat_inc(cnt_q[i]) : '0;
      end
    end
  end

  // Stage p1: the bank answers one cycle after acceptance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_vld_p1 <= 1'b0;
    end else if (clear_i) begin
      resp_vld_p1 <= 1'b0;
    end else begin
      resp_vld_p1 <= accept;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) resp_idx_p1 <= winner;
  end

endmodule

// File: rtl/hci_bank_qos_arbiter.sv
// Per-bank QoS arbiter for NB_BRANCH initiator branches onto N_MEM TCDM banks.
// Optional HCI_QOS_STATS_EN adds stall_cnt_o, per-branch stalled branch-bank cycle counters.
module hci_bank_qos_arbiter
  import hci_package::*;
#(
  parameter int unsigned NB_BRANCH = 3,
  parameter int unsigned N_MEM     = 16,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned CNT_W     = HCI_QOS_CNT_W,
  parameter int unsigned BW        = DW / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
`ifdef HCI_QOS_STATS_EN
  output logic [NB_BRANCH*32-1:0]       stall_cnt_o,
`endif
  input  logic                          clear_i,
  input  logic [CNT_W-1:0]              max_stall_i,
  input  logic                          invert_prio_i,
  input  logic [NB_BRANCH*N_MEM-1:0]    in_req_i,
  output logic [NB_BRANCH*N_MEM-1:0]    in_gnt_o,
  input  logic [NB_BRANCH*N_MEM*AW-1:0] in_add_i,
  input  logic [NB_BRANCH*N_MEM-1:0]    in_wen_i,
  input  logic [NB_BRANCH*N_MEM*DW-1:0] in_data_i,
  input  logic [NB_BRANCH*N_MEM*BW-1:0] in_be_i,
  output logic [NB_BRANCH*N_MEM-1:0]    in_r_valid_o,
  output logic [NB_BRANCH*N_MEM*DW-1:0] in_r_data_o,
  output logic [N_MEM-1:0]              mem_req_o,
  output logic [N_MEM*AW-1:0]           mem_add_o,
  output logic [N_MEM-1:0]              mem_wen_o,
  output logic [N_MEM*DW-1:0]           mem_data_o,
  output logic [N_MEM*BW-1:0]           mem_be_o,
  input  logic [N_MEM-1:0]              mem_gnt_i,
  input  logic [N_MEM*DW-1:0]           mem_r_data_i
);

  hci_qos_ctrl_t ctrl;

  assign ctrl.max_stall   = HCI_QOS_CNT_W'(max_stall_i);
  assign ctrl.invert_prio = invert_prio_i;

  for (genvar b = 0; b < N_MEM; b++) begin : g_bank
    logic [NB_BRANCH-1:0]         req_b, wen_b, gnt_b, rvld_b;
    logic [NB_BRANCH-1:0][AW-1:0] add_b;
    logic [NB_BRANCH-1:0][DW-1:0] data_b;
    logic [NB_BRANCH-1:0][BW-1:0] be_b;

    for (genvar br = 0; br < NB_BRANCH; br++) begin : g_br
      localparam int unsigned K = br * N_MEM + b;
      assign req_b[br]  = in_req_i[K];
      assign wen_b[br]  = in_wen_i[K];
      assign add_b[br]  = in_add_i[K*AW +: AW];
      assign data_b[br] = in_data_i[K*DW +: DW];
      assign be_b[br]   = in_be_i[K*BW +: BW];
      assign in_gnt_o[K]              = gnt_b[br];
      assign in_r_valid_o[K]          = rvld_b[br];
      assign in_r_data_o[K*DW +: DW]  = mem_r_data_i[b*DW +: DW];
    end

    hci_bank_qos_arbiter_chan #(
      .NB_BRANCH (NB_BRANCH),
      .AW        (AW),
      .DW        (DW),
      .CNT_W     (CNT_W),
      .BW        (BW)
    ) i_chan (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear_i),
      .ctrl_i     (ctrl),
      .req_i      (req_b),
      .add_i      (add_b),
      .wen_i      (wen_b),
      .data_i     (data_b),
      .be_i       (be_b),
      .gnt_o      (gnt_b),
      .r_valid_o  (rvld_b),
      .mem_req_o  (mem_req_o[b]),
      .mem_add_o  (mem_add_o[b*AW +: AW]),
      .mem_wen_o  (mem_wen_o[b]),
      .mem_data_o (mem_data_o[b*DW +: DW]),
      .mem_be_o   (mem_be_o[b*BW +: BW]),
      .mem_gnt_i  (mem_gnt_i[b])
    );
  end

`ifdef HCI_QOS_STATS_EN
  localparam int unsigned INC_W = $clog2(N_MEM + 1);

  logic [NB_BRANCH-1:0][INC_W-1:0] stall_inc;
  logic [NB_BRANCH-1:0][31:0]      stall_cnt_q;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [INC_W-1:0] d);
    logic [32:0] s;
    s = {1'b0, a} + 33'(d);
    return s[32] ? '1 : s[31:0];
  endfunction

  always_comb begin
    for (int br = 0; br < NB_BRANCH; br++) begin
      stall_inc[br] = '0;
      for (int b = 0; b < N_MEM; b++) begin
        stall_inc[br] = stall_inc[br] +
                        INC_W'(in_req_i[br*N_MEM+b] & ~in_gnt_o[br*N_MEM+b]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (clear_i) begin
      stall_cnt_q <= '0;
    end else begin
      for (int br = 0; br < NB_BRANCH; br++) begin
        stall_cnt_q[br] <= sat_add32(stall_cnt_q[br], stall_inc[br]);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hci_bank_qos_arbiter.sv
// Directed bench for hci_bank_qos_arbiter: priority, starvation override, inversion,
// bank back-pressure, reset during a grant and (with HCI_QOS_STATS_EN) stall statistics.
module tb_hci_bank_qos_arbiter;

  localparam int NB = 3;
  localparam int NM = 16;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int CW = 8;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                clear_i;
  logic [CW-1:0]       max_stall_i;
  logic                invert_prio_i;
  logic [NB*NM-1:0]    in_req_i;
  logic [NB*NM-1:0]    in_gnt_o;
  logic [NB*NM*AW-1:0] in_add_i;
  logic [NB*NM-1:0]    in_wen_i;
  logic [NB*NM*DW-1:0] in_data_i;
  logic [NB*NM*BW-1:0] in_be_i;
  logic [NB*NM-1:0]    in_r_valid_o;
  logic [NB*NM*DW-1:0] in_r_data_o;
  logic [NM-1:0]       mem_req_o;
  logic [NM*AW-1:0]    mem_add_o;
  logic [NM-1:0]       mem_wen_o;
  logic [NM*DW-1:0]    mem_data_o;
  logic [NM*BW-1:0]    mem_be_o;
  logic [NM-1:0]       mem_gnt_i;
  logic [NM*DW-1:0]    mem_r_data_i;
`ifdef HCI_QOS_STATS_EN
  logic [NB*32-1:0]    stall_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  hci_bank_qos_arbiter dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
`ifdef HCI_QOS_STATS_EN
    .stall_cnt_o   (stall_cnt_o),
`endif
    .clear_i       (clear_i),
    .max_stall_i   (max_stall_i),
    .invert_prio_i (invert_prio_i),
    .in_req_i      (in_req_i),
    .in_gnt_o      (in_gnt_o),
    .in_add_i      (in_add_i),
    .in_wen_i      (in_wen_i),
    .in_data_i     (in_data_i),
    .in_be_i       (in_be_i),
    .in_r_valid_o  (in_r_valid_o),
    .in_r_data_o   (in_r_data_o),
    .mem_req_o     (mem_req_o),
    .mem_add_o     (mem_add_o),
    .mem_wen_o     (mem_wen_o),
    .mem_data_o    (mem_data_o),
    .mem_be_o      (mem_be_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_r_data_i  (mem_r_data_i)
  );

  function automatic int gi(input int br, input int b);
    return br * NM + b;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni        = 1'b0;
    clear_i       = 1'b0;
    max_stall_i   = '0;
    invert_prio_i = 1'b0;
    in_req_i      = '0;
    in_add_i      = '0;
    in_wen_i      = '0;
    in_data_i     = '0;
    in_be_i       = '1;
    mem_gnt_i     = '1;
    mem_r_data_i  = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    @(negedge clk_i);
    check("reset_gnt",     64'(in_gnt_o),     64'd0);
    check("reset_rvalid",  64'(in_r_valid_o), 64'd0);
    check("reset_mem_req", 64'(mem_req_o),    64'd0);

    // Pure fixed priority on bank 3, long enough to saturate branch 1's counter.
    step();
    in_add_i[gi(0,3)*AW +: AW] = 32'h0000_1000;
    in_add_i[gi(1,3)*AW +: AW] = 32'h0000_2000;
    in_req_i[gi(0,3)] = 1'b1;
    in_req_i[gi(1,3)] = 1'b1;
    for (int k = 0; k < 260; k++) begin
      @(negedge clk_i);
      if (k < 5 || k == 259) begin
        check("fp_gnt0", 64'(in_gnt_o[gi(0,3)]), 64'd1);
        check("fp_gnt1", 64'(in_gnt_o[gi(1,3)]), 64'd0);
      end
      if (k == 0) check("fp_add", 64'(mem_add_o[3*AW +: AW]), 64'h1000);
      if (k >= 1 && k < 4) begin
        check("fp_rvld0", 64'(in_r_valid_o[gi(0,3)]), 64'd1);
        check("fp_rvld1", 64'(in_r_valid_o[gi(1,3)]), 64'd0);
      end
      step();
    end
    // Counter sits at 255: a threshold of 255 must force branch 1 in the same cycle.
    max_stall_i = 8'd255;
    @(negedge clk_i);
    check("sat_gnt1", 64'(in_gnt_o[gi(1,3)]), 64'd1);
    check("sat_gnt0", 64'(in_gnt_o[gi(0,3)]), 64'd0);

    // Starvation threshold 4: branch 1 wins every 5th cycle.
    step();
    in_req_i = '0;
    pulse_clear();
    max_stall_i = 8'd4;
    in_req_i[gi(0,3)] = 1'b1;
    in_req_i[gi(1,3)] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk_i);
      check("qos_gnt1", 64'(in_gnt_o[gi(1,3)]), (k % 5 == 4) ? 64'd1 : 64'd0);
      check("qos_gnt0", 64'(in_gnt_o[gi(0,3)]), (k % 5 == 4) ? 64'd0 : 64'd1);
      step();
    end

    // Inverted priority on bank 0, response steered to branch 2.
    in_req_i = '0;
    pulse_clear();
    max_stall_i   = '0;
    invert_prio_i = 1'b1;
    in_add_i[gi(0,0)*AW +: AW] = 32'h0000_0111;
    in_add_i[gi(2,0)*AW +: AW] = 32'h0000_0333;
    mem_r_data_i[0 +: DW] = 32'hCAFE_0003;
    in_req_i[gi(0,0)] = 1'b1;
    in_req_i[gi(2,0)] = 1'b1;
    @(negedge clk_i);
    check("inv_gnt2",    64'(in_gnt_o[gi(2,0)]),     64'd1);
    check("inv_gnt0",    64'(in_gnt_o[gi(0,0)]),     64'd0);
    check("inv_add",     64'(mem_add_o[0 +: AW]),    64'h333);
    check("inv_mem_req", 64'(mem_req_o[0]),          64'd1);
    step();
    in_req_i = '0;
    @(negedge clk_i);
    check("inv_rvld2", 64'(in_r_valid_o[gi(2,0)]),          64'd1);
    check("inv_rvld0", 64'(in_r_valid_o[gi(0,0)]),          64'd0);
    check("inv_rdata", 64'(in_r_data_o[gi(2,0)*DW +: DW]),  64'hCAFE_0003);
    step();
    @(negedge clk_i);
    check("inv_rvld_end", 64'(in_r_valid_o[gi(2,0)]), 64'd0);

    // Bank 5 back-pressure: branch 1 stalls 3 cycles, then its counter (3) forces it past branch 0.
    step();
    invert_prio_i = 1'b0;
    mem_gnt_i[5]  = 1'b0;
    in_req_i[gi(1,5)] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("bp_gnt1",  64'(in_gnt_o[gi(1,5)]),     64'd0);
      check("bp_req",   64'(mem_req_o[5]),          64'd1);
      check("bp_rvld1", 64'(in_r_valid_o[gi(1,5)]), 64'd0);
      step();
    end
    mem_gnt_i[5] = 1'b1;
    max_stall_i  = 8'd3;
    in_req_i[gi(0,5)] = 1'b1;
    @(negedge clk_i);
    check("bp_rise_gnt1", 64'(in_gnt_o[gi(1,5)]), 64'd1);
    check("bp_rise_gnt0", 64'(in_gnt_o[gi(0,5)]), 64'd0);
    step();
    in_req_i = '0;
    @(negedge clk_i);
    check("bp_rvld1", 64'(in_r_valid_o[gi(1,5)]), 64'd1);

    // Reset half a cycle after a grant drops its response and clears counters.
    step();
    max_stall_i = '0;
    in_req_i[gi(0,7)] = 1'b1;
    in_req_i[gi(1,7)] = 1'b1;
    repeat (6) step();
    @(negedge clk_i);
    check("rst_pre_gnt0", 64'(in_gnt_o[gi(0,7)]), 64'd1);
    rst_ni   = 1'b0;
    in_req_i = '0;
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge clk_i);
      check("rst_rvld0", 64'(in_r_valid_o[gi(0,7)]), 64'd0);
    end
    step();
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_post_rvld", 64'(in_r_valid_o), 64'd0);
    step();
    max_stall_i = 8'd1;
    in_req_i[gi(0,7)] = 1'b1;
    in_req_i[gi(1,7)] = 1'b1;
    @(negedge clk_i);
    check("rst_cnt0_gnt0", 64'(in_gnt_o[gi(0,7)]), 64'd1);
    step();
    @(negedge clk_i);
    check("rst_cnt1_gnt1", 64'(in_gnt_o[gi(1,7)]), 64'd1);
    step();
    in_req_i = '0;

`ifdef HCI_QOS_STATS_EN
    pulse_clear();
    max_stall_i = '0;
    in_req_i[gi(0,3)] = 1'b1;
    in_req_i[gi(1,3)] = 1'b1;
    repeat (10) @(posedge clk_i);
    #1 in_req_i = '0;
    @(negedge clk_i);
    check("stats_b1", 64'(stall_cnt_o[32 +: 32]), 64'd10);
    check("stats_b0", 64'(stall_cnt_o[0 +: 32]),  64'd0);
    step();
    pulse_clear();
    @(negedge clk_i);
    check("stats_clr", 64'(stall_cnt_o[32 +: 32]), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
